// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer: ALU input-select codes,
// one-hot operation selects and sequencer FSM state encodings.
package alu_pkg;

  // ALU in_sel codes, ordered {persist, load, reset}
  localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
  localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
  localparam logic [2:0] IN_SEL_RESET   = 3'b001;

  // One-hot ALU out_sel values (7-bit ALU)
  localparam logic [6:0] OP_SEL_0 = 7'b0000001;
  localparam logic [6:0] OP_SEL_1 = 7'b0000010;
  localparam logic [6:0] OP_SEL_2 = 7'b0000100;
  localparam logic [6:0] OP_SEL_3 = 7'b0001000;
  localparam logic [6:0] OP_SEL_4 = 7'b0010000;
  localparam logic [6:0] OP_SEL_5 = 7'b0100000;
  localparam logic [6:0] OP_SEL_6 = 7'b1000000;

  // Sequencer FSM states; encoding is visible on the debug state port
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU sequencer: DEPTH entries (power of 2, >= 2) of
// packed {op, a, b}. ready is a registered !full, so a pop while full only
// raises ready on the following cycle.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count - 1'b1;
    end
  end

  // Pointers, occupancy and registered ready; pointers wrap modulo DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      ready <= (count_next != FULL_CNT);
    end
  end

  // Entry storage, no reset needed on data
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the ALU operand/op-select interface. Queues host commands
// {op, a, b}, drives one ALU load cycle per command, waits ALU_LAT cycles,
// captures alu_out and holds it on a valid/ready response port. Commands
// whose op is not one-hot are answered with rsp_err=1 and no ALU cycle.
// Optional build macro ALU_SEQ_STATS_EN adds op_count[15:0], the number of
// error-free responses accepted (wraps at 16 bits).
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 7,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              alu_on,
  output logic [2:0]        alu_in_sel,
  output logic [DATA_W-1:0] alu_num1,
  output logic [DATA_W-1:0] alu_num2,
  output logic [OP_W-1:0]   alu_out_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [1:0]        state
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]       op_count
`endif
);

  localparam int ENTRY_W = OP_W + 2*DATA_W;
  localparam int CNT_W   = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(1);

  seq_state_t        state_q;
  seq_state_t        state_d;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_ready;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [OP_W-1:0]   head_op;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  logic              head_ok;
  logic [CNT_W-1:0]  lat_cnt;

  // True when exactly one bit of the op select is set
  function automatic logic is_one_hot(input logic [OP_W-1:0] v);
    logic [OP_W-1:0] m;
    m = v - 1'b1;
    return (v != '0) && ((v & m) == '0);
  endfunction

  assign fifo_wdata = {cmd_op, cmd_a, cmd_b};
  assign fifo_push  = cmd_valid && cmd_ready && !fifo_full;
  assign cmd_ready  = fifo_ready;
  assign head_op    = fifo_rdata[2*DATA_W +: OP_W];
  assign head_a     = fifo_rdata[DATA_W +: DATA_W];
  assign head_b     = fifo_rdata[0 +: DATA_W];
  assign head_ok    = is_one_hot(head_op);
  assign state      = state_q;

  alu_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ready (fifo_ready)
  );

  // Next-state and pop decision
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = head_ok ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (lat_cnt == LAT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts whatever is in flight
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Registered ALU drive: in_sel/operands follow the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_on      <= 1'b0;
      alu_in_sel  <= IN_SEL_RESET;
      alu_num1    <= '0;
      alu_num2    <= '0;
      alu_out_sel <= '0;
    end else begin
      alu_on     <= 1'b1;
      alu_in_sel <= (state_d == ST_LOAD) ? IN_SEL_LOAD : IN_SEL_PERSIST;
      if (fifo_pop && head_ok) begin
        alu_num1    <= head_a;
        alu_num2    <= head_b;
        alu_out_sel <= head_op;
      end
    end
  end

  // Latency counter: loaded leaving LOAD, counts down through WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt <= '0;
    end else if (state_q == ST_LOAD) begin
      lat_cnt <= LAT_INIT;
    end else if (state_q == ST_WAIT) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // Response registers: capture result or flag a bad op, hold until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fifo_pop && !head_ok) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_out;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  // Count error-free responses taken by the host
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (rsp_valid && rsp_ready && !rsp_err) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU with fixed latency, a queue of
// expected responses computed from each accepted command, and one task per
// scenario. Build with ALU_SEQ_STATS_EN to include the op_count scenario.
module tb_alu_cmd_sequencer;

  localparam int DATA_W  = 8;
  localparam int OP_W    = 7;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 2;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op = '0;
  logic [DATA_W-1:0] cmd_a = '0;
  logic [DATA_W-1:0] cmd_b = '0;
  logic              alu_on;
  logic [2:0]        alu_in_sel;
  logic [DATA_W-1:0] alu_num1;
  logic [DATA_W-1:0] alu_num2;
  logic [OP_W-1:0]   alu_out_sel;
  logic [DATA_W-1:0] alu_out;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [1:0]        state;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]       op_count;
`endif

  int   total = 0;
  int   bad = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .DATA_W  (DATA_W),
    .OP_W    (OP_W),
    .DEPTH   (DEPTH),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .alu_on      (alu_on),
    .alu_in_sel  (alu_in_sel),
    .alu_num1    (alu_num1),
    .alu_num2    (alu_num2),
    .alu_out_sel (alu_out_sel),
    .alu_out     (alu_out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .state       (state)
`ifdef ALU_SEQ_STATS_EN
    ,
    .op_count    (op_count)
`endif
  );

  // Reference ALU function for each one-hot select
  function automatic logic [DATA_W-1:0] ref_alu(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      7'b0000001: r = a + b;
      7'b0000010: r = a - b;
      7'b0000100: r = a & b;
      7'b0001000: r = a | b;
      7'b0010000: r = a ^ b;
      7'b0100000: r = ~a;
      7'b1000000: r = 8'(a * b);
      default:    r = '0;
    endcase
    return r;
  endfunction

  // Expected response of a command
  function automatic rsp_t model_rsp(input logic [OP_W-1:0] op,
                                     input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b);
    rsp_t r;
    r.err  = ($countones(op) != 1);
    r.data = r.err ? '0 : ref_alu(op, a, b);
    return r;
  endfunction

  // Behavioural ALU: result valid ALU_LAT edges after the load edge, junk before
  logic [DATA_W-1:0] alu_res = '0;
  int                alu_age = 100;
  always @(posedge clk) begin
    if (alu_in_sel == 3'b010) begin
      alu_res <= ref_alu(alu_out_sel, alu_num1, alu_num2);
      alu_age <= 0;
    end else if (alu_age < 100) begin
      alu_age <= alu_age + 1;
    end
  end
  assign alu_out = (alu_age >= ALU_LAT - 1) ? alu_res : ~alu_res;

  task automatic push_cmd(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b);
    int n = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL push_timeout: cmd_ready=%b required 1", cmd_ready);
    end else begin
      @(negedge clk);
      exp_q.push_back(model_rsp(op, a, b));
    end
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string name);
    int   n = 0;
    rsp_t e;
    while (!rsp_valid && n < 100) begin
      @(negedge clk); n++;
    end
    total++;
    if (!rsp_valid) begin
      bad++;
      $display("FAIL %s_timeout: rsp_valid=0 required 1", name);
      return;
    end
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_unexpected: rsp_data=%h with nothing outstanding", name, rsp_data);
    end else begin
      e = exp_q.pop_front();
      if (rsp_data !== e.data || rsp_err !== e.err) begin
        bad++;
        $display("FAIL %s_rsp: data=%h err=%b required data=%h err=%b",
                 name, rsp_data, rsp_err, e.data, e.err);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (alu_in_sel !== 3'b001) begin bad++; $display("FAIL reset_in_sel: got %b required 001", alu_in_sel); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    total++; if (alu_on !== 1'b0 || rsp_data !== '0 || rsp_err !== 1'b0) begin bad++; $display("FAIL reset_regs: on=%b data=%h err=%b required 0 00 0", alu_on, rsp_data, rsp_err); end
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    total++; if (alu_in_sel !== 3'b100) begin bad++; $display("FAIL release_in_sel: got %b required 100", alu_in_sel); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL release_cmd_ready: got %b required 1", cmd_ready); end
    total++; if (state !== 2'b00 || alu_on !== 1'b1) begin bad++; $display("FAIL release_state: state=%b on=%b required 00 1", state, alu_on); end
  endtask

  task automatic test_single_op();
    int n = 0;
    int lat = 0;
    push_cmd(7'b1000000, 8'h57, 8'h1A);
    while (alu_in_sel !== 3'b010 && n < 20) begin
      @(negedge clk); n++;
    end
    total++;
    if (alu_in_sel !== 3'b010 || alu_num1 !== 8'h57 || alu_num2 !== 8'h1A || alu_out_sel !== 7'b1000000) begin
      bad++;
      $display("FAIL single_load: in_sel=%b num1=%h num2=%h sel=%b required 010 57 1a 1000000",
               alu_in_sel, alu_num1, alu_num2, alu_out_sel);
    end
    while (!rsp_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    total++;
    if (lat != ALU_LAT + 1) begin
      bad++;
      $display("FAIL single_latency: load-to-rsp cycles=%0d required %0d", lat, ALU_LAT + 1);
    end
    get_rsp("single");
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] held;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(7'(1 << $urandom_range(0, 6)), 8'($urandom), 8'($urandom));
    end
    @(negedge clk);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_full: cmd_ready=%b required 0", cmd_ready); end
    while (!rsp_valid) @(negedge clk);
    held = rsp_data;
    repeat (6) @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== held) begin
      bad++;
      $display("FAIL bp_hold: valid=%b data=%h required 1 %h", rsp_valid, rsp_data, held);
    end
    get_rsp("bp");
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_pop_cycle: cmd_ready=%b required 0", cmd_ready); end
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_after_pop: cmd_ready=%b required 1", cmd_ready); end
    for (int i = 0; i < 4; i++) get_rsp("bp");
  endtask

  task automatic test_bad_op();
    logic [OP_W-1:0] ops [2];
    ops[0] = 7'b0000011;
    ops[1] = 7'b0000000;
    for (int k = 0; k < 2; k++) begin
      int  n = 0;
      bit  saw_load = 0;
      push_cmd(ops[k], 8'($urandom), 8'($urandom));
      while (!rsp_valid && n < 20) begin
        if (alu_in_sel === 3'b010) saw_load = 1;
        @(negedge clk); n++;
      end
      total++; if (saw_load) begin bad++; $display("FAIL bad_op_load: saw in_sel=010 for op %b required none", ops[k]); end
      get_rsp("bad_op");
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL bad_op_clear: rsp_err=%b required 0", rsp_err); end
    end
  endtask

  task automatic test_back_to_back();
    int   prev = -1;
    int   seen = 0;
    rsp_t e;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_cmd(7'(1 << $urandom_range(0, 6)), 8'($urandom), 8'($urandom));
    end
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (rsp_valid === 1'b1) begin
        total++;
        e = exp_q.pop_front();
        if (rsp_data !== e.data || rsp_err !== e.err) begin
          bad++;
          $display("FAIL b2b_rsp: data=%h err=%b required %h %b", rsp_data, rsp_err, e.data, e.err);
        end
        if (prev >= 0) begin
          total++;
          if (cyc - prev != ALU_LAT + 3) begin
            bad++;
            $display("FAIL b2b_gap: cycles=%0d required %0d", cyc - prev, ALU_LAT + 3);
          end
        end
        prev = cyc;
        seen++;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    total++; if (seen != 3) begin bad++; $display("FAIL b2b_count: responses=%0d required 3", seen); end
  endtask

  task automatic test_reset_in_wait();
    int n = 0;
    bit leak = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_cmd(7'(1 << $urandom_range(0, 6)), 8'($urandom), 8'($urandom));
    end
    while (state !== 2'b10 && n < 20) begin
      @(negedge clk); n++;
    end
    total++; if (state !== 2'b10) begin bad++; $display("FAIL rstwait_reach: state=%b required 10", state); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    total++;
    if (state !== 2'b00 || rsp_valid !== 1'b0 || alu_in_sel !== 3'b001) begin
      bad++;
      $display("FAIL rstwait_abort: state=%b valid=%b in_sel=%b required 00 0 001", state, rsp_valid, alu_in_sel);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 || alu_in_sel === 3'b010) leak = 1;
    end
    total++; if (leak) begin bad++; $display("FAIL rstwait_leak: activity after reset required none"); end
    total++;
    if (state !== 2'b00 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstwait_idle: state=%b cmd_ready=%b required 00 1", state, cmd_ready);
    end
  endtask

  task automatic test_random();
    localparam int N = 24;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          logic [OP_W-1:0] op;
          if ($urandom_range(0, 3) == 0) op = 7'($urandom);
          else                           op = 7'(1 << $urandom_range(0, 6));
          push_cmd(op, 8'($urandom), 8'($urandom));
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        for (int j = 0; j < N; j++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          get_rsp("random");
        end
      end
    join
  endtask

`ifdef ALU_SEQ_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    total++; if (op_count !== 16'd0) begin bad++; $display("FAIL stats_reset: op_count=%0d required 0", op_count); end
    push_cmd(7'b0000001, 8'h10, 8'h20);
    push_cmd(7'b0000110, 8'h11, 8'h22);
    push_cmd(7'b0010000, 8'h33, 8'h0F);
    push_cmd(7'b0100000, 8'h5A, 8'h00);
    for (int i = 0; i < 4; i++) get_rsp("stats");
    total++; if (op_count !== 16'd3) begin bad++; $display("FAIL stats_count: op_count=%0d required 3", op_count); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_op();
    test_backpressure();
    test_bad_op();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
`ifdef ALU_SEQ_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
